// File: rtl/flex_downcounter.sv
// flex_downcounter
//   Loadable down-counter with a start/done handshake. A start loads
//   start_val and enters RUN; each count_enable in RUN decrements the count,
//   and reaching zero produces a one-cycle done pulse (DONE state), after
//   which the block returns to IDLE. Loading zero goes straight to DONE.
//
//   Optional feature macro: FLEX_DOWNCOUNTER_AUTORELOAD_EN
//     Adds the reload input. On a terminal edge with reload high (and a
//     non-zero load value) the counter reloads from the last loaded value,
//     stays in RUN and still pulses done.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   clear         synchronous abort to IDLE, count 0, no done
//   start         load start_val and begin counting
//   start_val     [SIZE] initial count
//   count_enable  decrement qualifier (RUN only)
//   reload        auto-reload request (feature macro only)
//   count_out     [SIZE] registered count
//   busy          registered, high in RUN
//   done          registered one-cycle terminal pulse
//   zero_flag     registered, high when count_out == 0
module flex_downcounter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            start,
  input  logic [SIZE-1:0] start_val,
  input  logic            count_enable,
`ifdef FLEX_DOWNCOUNTER_AUTORELOAD_EN
  input  logic            reload,
`endif
  output logic [SIZE-1:0] count_out,
  output logic            busy,
  output logic            done,
  output logic            zero_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [SIZE-1:0] r_count;
  logic [SIZE-1:0] r_load;
  logic            r_busy;
  logic            r_done;
  logic            r_zero;

  logic [1:0]      w_state_nxt;
  logic [SIZE-1:0] w_count_nxt;
  logic [SIZE-1:0] w_load_nxt;
  logic            w_done_nxt;
  logic            w_terminal;

  // Last enabled decrement of a run: count is 1, so the next value is 0.
  assign w_terminal = (r_state == S_RUN) && count_enable &&
                      (r_count == SIZE'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load_nxt  = r_load;
    w_done_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
    end else if (start) begin
      // A start also overrides a coincident terminal edge: no done pulse.
      w_count_nxt = start_val;
      w_load_nxt  = start_val;
      if (start_val != '0) begin
        w_state_nxt = S_RUN;
      end else begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_terminal) begin
            w_done_nxt = 1'b1;
`ifdef FLEX_DOWNCOUNTER_AUTORELOAD_EN
            if (reload && (r_load != '0)) begin
              w_count_nxt = r_load;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = S_DONE;
            end
`else
            w_count_nxt = '0;
            w_state_nxt = S_DONE;
`endif
          end else if (count_enable) begin
            w_count_nxt = r_count - SIZE'(1);
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Flags are registered from the next-state values so they line up with
  // count_out and the state on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_load  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_load  <= w_load_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= w_done_nxt;
      r_zero  <= (w_count_nxt == '0);
    end
  end

  assign count_out = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign zero_flag = r_zero;

endmodule

// File: tb/tb_flex_downcounter.sv
module tb_flex_downcounter;
  localparam int SIZE = 4;
`ifdef FLEX_DOWNCOUNTER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0, clear = 1'b0, start = 1'b0, count_enable = 1'b0;
  logic            reload = 1'b0;
  logic [SIZE-1:0] start_val = '0;
  logic [SIZE-1:0] count_out;
  logic            busy, done, zero_flag;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: remaining count, whether a run is active, done pulse.
  int m_cnt = 0, m_load = 0;
  bit m_act = 1'b0, m_dn = 1'b0;

  always #5 clk = ~clk;

  flex_downcounter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .start_val(start_val), .count_enable(count_enable),
`ifdef FLEX_DOWNCOUNTER_AUTORELOAD_EN
    .reload(reload),
`endif
    .count_out(count_out), .busy(busy), .done(done), .zero_flag(zero_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model with the spec rules,
  // then compare all outputs shortly after the edge.
  task automatic cyc(input bit r, input bit c, input bit s, input int sv,
                     input bit ce, input bit rl);
    rst = r; clear = c; start = s; start_val = SIZE'(sv);
    count_enable = ce; reload = rl;
    @(posedge clk);
    if (r || c) begin
      m_cnt = 0; m_act = 0; m_dn = 0;
    end else if (s) begin
      m_cnt = sv; m_load = sv;
      m_act = (sv != 0);
      m_dn  = (sv == 0);
    end else if (m_act && ce) begin
      if (m_cnt == 1) begin
        m_dn = 1;
        if (AR && rl && m_load != 0) m_cnt = m_load;
        else begin m_cnt = 0; m_act = 0; end
      end else begin
        m_cnt = m_cnt - 1; m_dn = 0;
      end
    end else begin
      m_dn = 0;
    end
    #1;
    chk("count_out", 32'(count_out), 32'(m_cnt));
    chk("busy",      32'(busy),      32'(m_act));
    chk("done",      32'(done),      32'(m_dn));
    chk("zero_flag", 32'(zero_flag), 32'(m_cnt == 0));
  endtask

  initial begin
    int seq5[6];
    int seq3[6];
    int ce3[5];
    int ndone;
    seq5 = '{5, 4, 3, 2, 1, 0};
    seq3 = '{3, 2, 2, 1, 1, 0};
    ce3  = '{1, 0, 1, 0, 1};
    #2;
    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_count", 32'(count_out), 0);
    chk("rst_zero",  32'(zero_flag), 1);

    // Load 5, count down with enable held
    cyc(0, 0, 1, 5, 1, 0);
    chk("seq5_0", 32'(count_out), 32'(seq5[0]));
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("seq5", 32'(count_out), 32'(seq5[i]));
    end
    chk("seq5_done", 32'(done), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("seq5_done_clr", 32'(done), 0);

    // Gated enable
    cyc(0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, ce3[i] != 0, 0);
      chk("gated", 32'(count_out), 32'(seq3[i+1]));
    end
    chk("gated_done", 32'(done), 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Zero load
    cyc(0, 0, 1, 0, 1, 0);
    chk("zload_done", 32'(done), 1);
    chk("zload_busy", 32'(busy), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("zload_done2", 32'(done), 0);

    // Full scale, no wrap
    cyc(0, 0, 1, 15, 1, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("max_end", 32'(count_out), 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("max_nowrap", 32'(count_out), 0);

    // Clear at count 2
    cyc(0, 0, 1, 4, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pre_clear", 32'(count_out), 2);
    cyc(0, 1, 0, 0, 1, 0);
    chk("clear_done", 32'(done), 0);
    chk("clear_busy", 32'(busy), 0);

    // Start coincident with terminal edge
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 4, 1, 0);
    chk("restart_cnt",  32'(count_out), 4);
    chk("restart_done", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    cyc(0, 1, 0, 0, 0, 0);

    // Reload stimulus; one-shot unless the feature is built in
    ndone = 0;
    cyc(0, 0, 1, 2, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 1, 1);
      ndone += int'(done);
    end
    chk("reload_pulses", 32'(ndone), AR ? 32'd4 : 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("reload_stop", 32'(busy), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c, s, ce, rl;
      int sv;
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 9) == 0);
      ce = ($urandom_range(0, 3) != 0);
      rl = $urandom_range(0, 1) != 0;
      sv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
      cyc(r, c, s, sv, ce, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/flex_downcounter.md
# flex_downcounter

Parameterised loadable down-counter with a start/done handshake, the counterpart to the existing up-counting flex_counter. A controller loads a start value and issues `start`. The block decrements on each `count_enable` and returns a one-cycle `done` pulse when the count reaches zero. It sits alongside flex_counter in the timing and shift-control datapaths, anywhere a fixed number of enabled cycles must elapse before an action.

## Interface
- SIZE, 4, counter width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort: return to IDLE with count 0, no `done` pulse.
- start  input  1  load `start_val` and begin counting; a level sampled each edge.
- start_val  input  SIZE  initial count, captured only on the edge where `start` is accepted.
- count_enable  input  1  decrement qualifier; ignored outside RUN.
- reload  input  1  auto-reload request; port exists only with FLEX_DOWNCOUNTER_AUTORELOAD_EN.
- count_out  output  SIZE  current count, registered.
- busy  output  1  high while in RUN, registered.
- done  output  1  one-cycle terminal pulse, registered.
- zero_flag  output  1  high when `count_out == 0`, registered.

## Operation
- States:
  - IDLE: waiting; `count_out` holds its last value, 0 after reset.
  - RUN: counting.
  - DONE: lasts exactly one cycle, then IDLE.
- Input priority per edge: `rst` > `clear` > `start` > `count_enable`.
- `start` accepted in any state, including a restart mid-RUN:
  - `count_out <= start_val` and an internal `load_reg <= start_val`.
  - If `start_val != 0`: enter RUN.
  - If `start_val == 0`: enter DONE directly (`done` = 1 the next cycle).
- RUN with `count_enable` = 1 and `count_out > 1`: `count_out <= count_out - 1`.
- RUN with `count_enable` = 1 and `count_out == 1` (terminal edge): `count_out <= 0` and enter DONE.
- RUN with `count_enable` = 0: hold.
- DONE: next edge goes to IDLE unless `start` is asserted.
- `start` on the terminal edge wins: the counter reloads and no `done` pulse is produced.
- `clear` in any state: `count_out <= 0`, go to IDLE, `busy` = 0, `done` = 0.
- Arithmetic is unsigned, width SIZE. `count_out` never underflows below 0 and never wraps to 2^SIZE−1.
- `count_enable` in IDLE or DONE has no effect.

## Timing
- Reset values: `count_out` = 0, `busy` = 0, `done` = 0, `zero_flag` = 1, state IDLE.
- Latency from `start` sampled at edge N:
  - `busy` and `count_out = start_val` are visible after edge N.
  - With `count_enable` held high, `done` = 1 in the cycle after edge N + `start_val`.
  - Total: `start_val` enabled cycles, with `done` pulsing during the `start_val`+1'th cycle.
- `busy` falls on the same edge on which `done` rises. `done` is high for exactly one cycle.
- `zero_flag` tracks `count_out` on the same edge. It is never derived combinationally from inputs.
- Reset or `clear` asserted mid-RUN takes effect at that edge. No `done` pulse is produced, and it overrides a coincident terminal edge.

## Configuration
- FLEX_DOWNCOUNTER_AUTORELOAD_EN defined:
  - The `reload` port exists.
  - On a terminal edge with `reload` = 1: `count_out <= load_reg`, state stays RUN, `busy` stays 1, `done` still pulses for one cycle.
  - If `load_reg == 0`, `reload` is ignored and normal DONE entry occurs.
- FLEX_DOWNCOUNTER_AUTORELOAD_EN undefined:
  - No `reload` port.
  - Always one-shot: terminal edge goes to DONE, then IDLE.

## Test plan
- Reset check: `rst` = 1 for 2 cycles → `count_out` = 0, `busy` = 0, `done` = 0, `zero_flag` = 1. Then `start_val` = 5, `start` for 1 cycle, `count_enable` = 1 → `count_out` 5,4,3,2,1,0; `done` high for one cycle exactly 5 edges after load; `busy` low from then.
- Gated enable: `start_val` = 3; `count_enable` toggles 1,0,1,0,1 → `count_out` 3,2,2,1,1,0; `done` on the fifth edge after load.
- Zero load and priority:
  - `start_val` = 0 → `done` pulses the cycle after load; `busy` never asserts; `zero_flag` stays 1.
  - SIZE = 4, `start_val` = 15 → 15 decrements to 0, no wrap.
- Mid-operation abort: `clear` at `count_out` = 2 → `count_out` = 0, IDLE, no `done`. Separately, `start` (`start_val` = 4) coincident with the terminal edge → `count_out` = 4, no `done`, `busy` = 1.
- Auto-reload (macro defined): `start_val` = 2, `reload` = 1, enable held → `count_out` 2,1,2,1,…; `done` every 2 cycles; `busy` stays 1. Dropping `reload` → next terminal edge leads to DONE then IDLE. With the macro undefined, the same stimulus stops after the first `done`.
